// File: rtl/charram_access_sequencer.sv
// charram_access_sequencer: 4416-style 16Kx4 character DRAM sequencer.
// Arbitrates video fetch, CPU access and RAS-only refresh.
//
// Ports:
//   i_MCLK, i_RST        clock, async active-high reset
//   i_VID_REQ/ADDR       video fetch request (level) and address
//   o_VID_DATA/VLD       video read data and one-cycle completion
//   i_CPU_REQ/WR/ADDR/DIN  CPU request, held until o_CPU_ACK
//   o_CPU_DOUT/ACK       CPU read data and one-cycle completion
//   o_ADDR, o_DIN, i_DOUT  DRAM mux address, write data, read data
//   o_RAS_n..o_RD_n      DRAM strobes, active low
//   o_BUSY               sequencer not idle
`timescale 1ns/1ps
module charram_access_sequencer #(
  parameter int PRE_CYC     = 2,
  parameter int RFSH_PERIOD = 140
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_VID_REQ,
  input  logic [13:0] i_VID_ADDR,
  output logic [3:0]  o_VID_DATA,
  output logic        o_VID_VLD,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic [3:0]  o_CPU_DOUT,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_ADDR,
  output logic [3:0]  o_DIN,
  input  logic [3:0]  i_DOUT,
  output logic        o_RAS_n,
  output logic        o_CAS_n,
  output logic        o_WR_n,
  output logic        o_RD_n,
  output logic        o_BUSY
);

  localparam int RW = $clog2(RFSH_PERIOD);
  localparam logic [RW-1:0] RF_LAST = RW'(RFSH_PERIOD - 1);
  localparam logic [2:0] PRE_LAST = 3'(PRE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RAS, S_CAS, S_XFER,
    S_CAP, S_PRE, S_RFA, S_RFB
  } state_t;

  typedef enum logic [1:0] {
    OWN_VID, OWN_CPU, OWN_RF
  } own_t;

  state_t          state_q, state_d;
  own_t            own_q, own_d;
  logic [13:0]     addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [3:0]      din_q, din_d;
  logic [2:0]      pre_q, pre_d;
  logic [RW-1:0]   tmr_q, tmr_d;
  logic [7:0]      rrow_q, rrow_d;
  logic            pend_q, pend_d;
  logic [3:0]      vdat_q, vdat_d;
  logic [3:0]      cdat_q, cdat_d;

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      own_q   <= OWN_VID;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      pre_q   <= '0;
      tmr_q   <= '0;
      rrow_q  <= '0;
      pend_q  <= 1'b0;
      vdat_q  <= '0;
      cdat_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      pre_q   <= pre_d;
      tmr_q   <= tmr_d;
      rrow_q  <= rrow_d;
      pend_q  <= pend_d;
      vdat_q  <= vdat_d;
      cdat_q  <= cdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    din_d   = din_q;
    pre_d   = pre_q;
    rrow_d  = rrow_q;
    pend_d  = pend_q;
    vdat_d  = vdat_q;
    cdat_d  = cdat_q;

    // A wrap that lands on the refresh grant is absorbed by it.
    if (tmr_q == RF_LAST) begin
      tmr_d  = '0;
      pend_d = 1'b1;
    end else begin
      tmr_d  = tmr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_VID_REQ) begin
          state_d = S_RAS;
          own_d   = OWN_VID;
          addr_d  = i_VID_ADDR;
          wr_d    = 1'b0;
        end else if (pend_q) begin
          state_d = S_RFA;
          own_d   = OWN_RF;
          pend_d  = 1'b0;
        end else if (i_CPU_REQ) begin
          state_d = S_RAS;
          own_d   = OWN_CPU;
          addr_d  = i_CPU_ADDR;
          wr_d    = i_CPU_WR;
          din_d   = i_CPU_DIN;
        end
      end
      S_RAS:  state_d = S_CAS;
      S_CAS:  state_d = S_XFER;
      S_XFER: state_d = S_CAP;
      S_CAP: begin
        state_d = S_PRE;
        pre_d   = '0;
        if (!wr_q) begin
          if (own_q == OWN_VID) vdat_d = i_DOUT;
          else if (own_q == OWN_CPU) cdat_d = i_DOUT;
        end
      end
      S_PRE: begin
        if (pre_q == PRE_LAST) state_d = S_IDLE;
        else pre_d = pre_q + 1'b1;
      end
      S_RFA:  state_d = S_RFB;
      S_RFB: begin
        state_d = S_PRE;
        pre_d   = '0;
        rrow_d  = rrow_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_RAS_n   = 1'b1;
    o_CAS_n   = 1'b1;
    o_WR_n    = 1'b1;
    o_RD_n    = 1'b1;
    o_ADDR    = '0;
    o_DIN     = '0;
    o_VID_VLD = 1'b0;
    o_CPU_ACK = 1'b0;
    o_BUSY    = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: ;
      S_RAS: begin
        o_RAS_n = 1'b0;
        o_ADDR  = addr_q[7:0];
      end
      S_CAS: begin
        o_RAS_n = 1'b0;
        o_CAS_n = 1'b0;
        o_ADDR  = {1'b0, addr_q[13:8], 1'b0};
      end
      S_XFER: begin
        o_RAS_n = 1'b0;
        o_CAS_n = 1'b0;
        o_ADDR  = {1'b0, addr_q[13:8], 1'b0};
        if (wr_q) begin
          o_WR_n = 1'b0;
          o_DIN  = din_q;
        end else begin
          o_RD_n = 1'b0;
        end
      end
      S_CAP: o_RAS_n = 1'b0;
      S_PRE: begin
        // Completion strobe only on the first precharge cycle.
        if (pre_q == '0) begin
          o_VID_VLD = (own_q == OWN_VID);
          o_CPU_ACK = (own_q == OWN_CPU);
        end
      end
      S_RFA, S_RFB: begin
        o_RAS_n = 1'b0;
        o_ADDR  = rrow_q;
      end
      default: ;
    endcase
  end

  assign o_VID_DATA = vdat_q;
  assign o_CPU_DOUT = cdat_q;

endmodule

// File: tb/tb_charram_access_sequencer.sv
// tb_charram_access_sequencer: directed bench with a 16Kx4 DRAM model.
// Second instance (PRE_CYC=1) covers the held-request regrant.
`timescale 1ns/1ps
module tb_charram_access_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [3:0]  cpu_din = '0;
  logic        b_req = 1'b0;

  logic [3:0]  a_vdata, a_cdout, a_din, m_dout;
  logic        a_vld, a_ack, a_busy;
  logic [7:0]  a_addr;
  logic        a_ras_n, a_cas_n, a_wr_n, a_rd_n;

  logic [3:0]  b_vdata, b_cdout, b_din;
  logic        b_vld, b_ack, b_busy;
  logic [7:0]  b_addr;
  logic        b_ras_n, b_cas_n, b_wr_n, b_rd_n;

  always #5 clk = ~clk;

  charram_access_sequencer u_dut (
    .i_MCLK(clk), .i_RST(rst),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr),
    .o_VID_DATA(a_vdata), .o_VID_VLD(a_vld),
    .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr),
    .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_DOUT(a_cdout), .o_CPU_ACK(a_ack),
    .o_ADDR(a_addr), .o_DIN(a_din), .i_DOUT(m_dout),
    .o_RAS_n(a_ras_n), .o_CAS_n(a_cas_n),
    .o_WR_n(a_wr_n), .o_RD_n(a_rd_n),
    .o_BUSY(a_busy)
  );

  charram_access_sequencer #(
    .PRE_CYC(1), .RFSH_PERIOD(64)
  ) u_dut1 (
    .i_MCLK(clk), .i_RST(rst),
    .i_VID_REQ(1'b0), .i_VID_ADDR(14'h0),
    .o_VID_DATA(b_vdata), .o_VID_VLD(b_vld),
    .i_CPU_REQ(b_req), .i_CPU_WR(cpu_wr),
    .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_DOUT(b_cdout), .o_CPU_ACK(b_ack),
    .o_ADDR(b_addr), .o_DIN(b_din), .i_DOUT(4'h9),
    .o_RAS_n(b_ras_n), .o_CAS_n(b_cas_n),
    .o_WR_n(b_wr_n), .o_RD_n(b_rd_n),
    .o_BUSY(b_busy)
  );

  // DRAM model: row on RAS fall, column on CAS fall,
  // write while WR_n low, read data registered while RD_n low.
  logic [3:0] mem [0:16383];
  bit         wrt [0:16383];
  logic [7:0] m_row = '0, m_cadr = '0, last_row = '0;
  logic       ras_p = 1'b1, cas_p = 1'b1;
  int         ras_falls = 0, cas_falls = 0;
  int         n_vld = 0, n_ack = 0, nb_vld = 0;
  logic [7:0] rowlog [$];

  function automatic logic [3:0] rdmem(input logic [13:0] ix);
    return wrt[ix] ? mem[ix] : (ix[3:0] ^ ix[11:8]);
  endfunction

  always @(posedge clk) begin
    if (!a_ras_n && ras_p) begin
      m_row <= a_addr;
      ras_falls <= ras_falls + 1;
      rowlog.push_back(a_addr);
    end
    if (!a_cas_n && cas_p) begin
      m_cadr <= a_addr;
      last_row <= m_row;
      cas_falls <= cas_falls + 1;
    end
    if (!a_wr_n) begin
      mem[{m_cadr[6:1], m_row}] <= a_din;
      wrt[{m_cadr[6:1], m_row}] <= 1'b1;
    end
    if (!a_rd_n) m_dout <= rdmem({m_cadr[6:1], m_row});
    ras_p <= a_ras_n;
    cas_p <= a_cas_n;
    if (a_vld) n_vld <= n_vld + 1;
    if (a_ack) n_ack <= n_ack + 1;
    if (b_vld) nb_vld <= nb_vld + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rowlog.delete();
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40 && a_busy; i++) @(negedge clk);
  endtask

  task automatic cpu_op(input logic wr, input logic [13:0] ad,
                        input logic [3:0] dn, input bit scr,
                        output int lat, output logic [3:0] dat);
    cpu_wr = wr; cpu_addr = ad; cpu_din = dn; cpu_req = 1'b1;
    lat = 0; dat = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (scr && i == 1) begin
        cpu_addr = ~ad; cpu_din = ~dn;
      end
      if (a_ack) begin
        lat = i; dat = a_cdout; break;
      end
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [3:0]  din;
    logic [7:0]  row;
    logic [7:0]  cadr;
    logic [3:0]  dat;
  } vec_t;

  vec_t tbl [8];
  int lat, vt, ct, a1, a2, nb, s_ras, s_cas, s_vld, s_ack;
  logic [3:0] dat, vdat, cdat;

  initial begin
    tbl[0] = '{1'b1, 14'h02A5, 4'hC, 8'hA5, 8'h04, 4'h0};
    tbl[1] = '{1'b0, 14'h02A5, 4'h0, 8'hA5, 8'h04, 4'hC};
    tbl[2] = '{1'b1, 14'h0000, 4'h3, 8'h00, 8'h00, 4'h0};
    tbl[3] = '{1'b1, 14'h3FFF, 4'h5, 8'hFF, 8'h7E, 4'h0};
    tbl[4] = '{1'b0, 14'h0000, 4'h0, 8'h00, 8'h00, 4'h3};
    tbl[5] = '{1'b0, 14'h3FFF, 4'h0, 8'hFF, 8'h7E, 4'h5};
    tbl[6] = '{1'b1, 14'h1234, 4'hA, 8'h34, 8'h24, 4'h0};
    tbl[7] = '{1'b0, 14'h1234, 4'h0, 8'h34, 8'h24, 4'hA};

    repeat (2) @(negedge clk);
    chk("rst_strobes", {a_ras_n, a_cas_n, a_wr_n, a_rd_n}, 4'hF);
    chk("rst_addr", a_addr, 8'h00);
    chk("rst_din", a_din, 4'h0);
    chk("rst_vdata", a_vdata, 4'h0);
    chk("rst_cdout", a_cdout, 4'h0);
    chk("rst_flags", {a_vld, a_ack, a_busy}, 3'b000);
    rst = 1'b0;
    rowlog.delete();

    // CPU write/read table.
    foreach (tbl[k]) begin
      wait_idle();
      cpu_op(tbl[k].wr, tbl[k].addr, tbl[k].din, 1'b1, lat, dat);
      chk($sformatf("tbl%0d_lat", k), lat, 5);
      chk($sformatf("tbl%0d_row", k), last_row, tbl[k].row);
      chk($sformatf("tbl%0d_col", k), m_cadr, tbl[k].cadr);
      if (!tbl[k].wr) chk($sformatf("tbl%0d_dat", k), dat, tbl[k].dat);
    end

    // Video and CPU in the same IDLE.
    do_reset();
    vid_addr = 14'h3FFF; vid_req = 1'b1;
    cpu_wr = 1'b0; cpu_addr = 14'h0000; cpu_req = 1'b1;
    vt = 0; ct = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) vid_req = 1'b0;
      if (a_vld) begin vt = i; vdat = a_vdata; end
      if (a_ack) begin ct = i; cdat = a_cdout; cpu_req = 1'b0; break; end
    end
    cpu_req = 1'b0;
    chk("vc_vld_lat", vt, 5);
    chk("vc_ack_gap", ct - vt, 7);
    chk("vc_vdat", vdat, 4'h5);
    chk("vc_cdat", cdat, 4'h3);

    // Idle refresh only.
    do_reset();
    s_ras = ras_falls; s_cas = cas_falls;
    s_vld = n_vld; s_ack = n_ack;
    repeat (3 * 140 + 6) @(negedge clk);
    chk("rf_count", ras_falls - s_ras, 3);
    chk("rf_cas", cas_falls - s_cas, 0);
    chk("rf_nlog", rowlog.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rf_row%0d", i),
          (i < rowlog.size()) ? rowlog[i] : 8'hEE, i);
    chk("rf_novld", n_vld - s_vld, 0);
    chk("rf_noack", n_ack - s_ack, 0);

    // Refresh pending meets CPU request.
    do_reset();
    repeat (140) @(negedge clk);
    s_ras = ras_falls;
    cpu_op(1'b0, 14'h1234, 4'h0, 1'b0, lat, dat);
    chk("rc_lat", lat, 10);
    chk("rc_ras", ras_falls - s_ras, 2);
    chk("rc_row0", (rowlog.size() > 0) ? rowlog[0] : 8'hEE, 8'h00);
    chk("rc_row1", (rowlog.size() > 1) ? rowlog[1] : 8'hEE, 8'h34);
    chk("rc_dat", dat, 4'hA);

    // Video pre-empts both pending refresh and CPU.
    wait_idle();
    do_reset();
    repeat (140) @(negedge clk);
    vid_addr = 14'h02A5; vid_req = 1'b1;
    cpu_wr = 1'b0; cpu_addr = 14'h3FFF; cpu_req = 1'b1;
    vt = 0; ct = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) vid_req = 1'b0;
      if (a_vld) begin vt = i; vdat = a_vdata; end
      if (a_ack) begin ct = i; cdat = a_cdout; cpu_req = 1'b0; break; end
    end
    cpu_req = 1'b0;
    chk("vrc_vld_lat", vt, 5);
    chk("vrc_ack_lat", ct, 17);
    chk("vrc_row0", (rowlog.size() > 0) ? rowlog[0] : 8'hEE, 8'hA5);
    chk("vrc_row1", (rowlog.size() > 1) ? rowlog[1] : 8'hEE, 8'h00);
    chk("vrc_row2", (rowlog.size() > 2) ? rowlog[2] : 8'hEE, 8'hFF);
    chk("vrc_vdat", vdat, 4'hC);
    chk("vrc_cdat", cdat, 4'h5);

    // Reset during XFER of a CPU write.
    wait_idle();
    do_reset();
    cpu_wr = 1'b1; cpu_addr = 14'h00AB; cpu_din = 4'h7; cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("ab_in_xfer", {a_ras_n, a_cas_n, a_wr_n, a_rd_n}, 4'b0001);
    s_ack = n_ack;
    rst = 1'b1;
    #1;
    chk("ab_strobes", {a_ras_n, a_cas_n, a_wr_n, a_rd_n}, 4'hF);
    chk("ab_busy", {a_busy, a_ack}, 2'b00);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_noack", n_ack - s_ack, 0);
    cpu_op(1'b0, 14'h00AB, 4'h0, 1'b0, lat, dat);
    chk("ab_lat", lat, 5);
    chk("ab_dat", dat, 4'hB);

    // Held CPU request is regranted (PRE_CYC=1 instance).
    wait_idle();
    do_reset();
    cpu_wr = 1'b0; cpu_addr = 14'h02A5; b_req = 1'b1;
    a1 = 0; a2 = 0; nb = 0; s_vld = nb_vld;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) chk("rg_row", b_addr, 8'hA5);
      if (i == 2) chk("rg_col", b_addr, 8'h04);
      if (i == 3) begin
        chk("rg_xfer", {b_ras_n, b_cas_n, b_wr_n, b_rd_n}, 4'b0010);
        chk("rg_din", b_din, 4'h0);
      end
      if (b_ack) begin
        nb++;
        chk("rg_dout", b_cdout, 4'h9);
        if (a1 == 0) a1 = i;
        else a2 = i;
      end
      if (a1 != 0 && i == a1 + 2) b_req = 1'b0;
    end
    b_req = 1'b0;
    chk("rg_ack1", a1, 5);
    chk("rg_ack2", a2, 11);
    chk("rg_nack", nb, 2);
    chk("rg_novld", nb_vld - s_vld, 0);
    chk("rg_idle", {b_busy, b_vdata}, 5'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
